// File: rtl/fpm_rr_scheduler.sv
// Round-robin front end that shares one two-stage registered FP multiplier among
// NUM_REQ requesters, with a tag pipe routing each result back to its owner.
module fpm_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   mul_en,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [31:0]            mul_result,
    input  logic                   mul_overflow,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_result,
    output logic                   resp_overflow,
    input  logic                   resp_ready,
    output logic [ID_W:0]          in_flight
);

    logic               stall;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               hi_hit;
    logic               lo_hit;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic [ID_W-1:0]    ptr;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] next_valid;
    logic [ID_W-1:0]    tag_id [LATENCY];
    logic [ID_W:0]      valid_count;

    assign resp_valid    = tag_valid[LATENCY-1];
    assign resp_id       = tag_id[LATENCY-1];
    assign resp_result   = resp_valid ? mul_result : 32'd0;
    assign resp_overflow = resp_valid & mul_overflow;
    assign stall         = resp_valid & ~resp_ready;
    assign mul_en        = ~stall;

    // Lowest requester above the last winner takes priority; otherwise wrap to the lowest at or below it.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) > ptr) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_id  = ID_W'(i);
                end
            end
        end
        grant_valid = (hi_hit | lo_hit) & ~stall & reset;
        grant_id    = hi_hit ? hi_id : lo_id;
    end

    always_comb begin
        req_ready = '0;
        mul_a     = 32'd0;
        mul_b     = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_a        = req_a[32*i +: 32];
                mul_b        = req_b[32*i +: 32];
            end
        end
    end

    // in_flight is registered, so it is counted from the valids the pipe is about to hold.
    always_comb begin
        next_valid    = '0;
        next_valid[0] = grant_valid;
        for (int i = 1; i < LATENCY; i++) begin
            next_valid[i] = tag_valid[i-1];
        end
        valid_count = '0;
        for (int i = 0; i < LATENCY; i++) begin
            valid_count = valid_count + (ID_W+1)'(next_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
            ptr       <= ID_W'(NUM_REQ - 1);
            in_flight <= '0;
        end else if (mul_en) begin
            tag_valid <= next_valid;
            tag_id[0] <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
            in_flight <= valid_count;
            if (grant_valid) begin
                ptr <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// Bench for fpm_rr_scheduler: models the shared two-stage multiplier and checks the
// scheduler every cycle against a queue-based reference of in-flight operations.
`timescale 1ns/1ps
module tb_fpm_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mul_en;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic [31:0]           mul_result;
    logic                  mul_overflow;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_result;
    logic                  resp_overflow;
    logic                  resp_ready;
    logic [ID_W:0]         in_flight;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        logic            ovf;
        int              age;
    } op_t;

    op_t q[$];
    int  mptr = NUM_REQ - 1;
    int  n_issued = 0;
    int  n_retired = 0;

    fpm_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_overflow(mul_overflow), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_ready(resp_ready), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    // Truncating single-precision multiply; returns {overflow, result}.
    function automatic logic [32:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), m};
    endfunction

    logic [31:0] ma_q, mb_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_q <= '0; mb_q <= '0; mul_result <= '0; mul_overflow <= 1'b0;
        end else if (mul_en) begin
            ma_q <= mul_a;
            mb_q <= mul_b;
            {mul_overflow, mul_result} <= fpmul(ma_q, mb_q);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: ops live in a queue in issue order, each aging one step per enabled edge.
    always @(negedge clk) begin : compare
        logic               head_valid, mstall, hit;
        logic [ID_W-1:0]    gid;
        logic [NUM_REQ-1:0] exp_ready;
        logic [31:0]        ea, eb;
        logic [32:0]        prod;
        int                 c;
        op_t                e;
        if (!reset) begin
            q.delete();
            mptr = NUM_REQ - 1;
            n_issued = 0;
            n_retired = 0;
            check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
            check_output("rst_in_flight", 32'(in_flight), 32'd0);
            check_output("rst_req_ready", 32'(req_ready), 32'd0);
            check_output("rst_mul_en", 32'(mul_en), 32'd1);
        end else begin
            head_valid = (q.size() > 0) && (q[0].age == LATENCY);
            mstall = head_valid && !resp_ready;
            hit = 1'b0;
            gid = '0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (mptr + k) % NUM_REQ;
                if (!hit && !mstall && req_valid[c]) begin
                    hit = 1'b1;
                    gid = c[ID_W-1:0];
                end
            end
            exp_ready = '0;
            ea = 32'd0;
            eb = 32'd0;
            if (hit) begin
                exp_ready[gid] = 1'b1;
                ea = req_a[32*gid +: 32];
                eb = req_b[32*gid +: 32];
            end
            check_output("resp_valid", 32'(resp_valid), 32'(head_valid));
            if (head_valid) begin
                check_output("resp_id", 32'(resp_id), 32'(q[0].id));
                check_output("resp_result", resp_result, q[0].result);
                check_output("resp_overflow", 32'(resp_overflow), 32'(q[0].ovf));
            end
            check_output("mul_en", 32'(mul_en), 32'(!mstall));
            check_output("req_ready", 32'(req_ready), 32'(exp_ready));
            check_output("mul_a", mul_a, ea);
            check_output("mul_b", mul_b, eb);
            check_output("in_flight", 32'(in_flight), 32'(q.size()));
            if (!mstall) begin
                if (head_valid) begin
                    void'(q.pop_front());
                    n_retired++;
                end
                foreach (q[i]) q[i].age++;
                if (hit) begin
                    prod = fpmul(ea, eb);
                    e.id = gid;
                    e.result = prod[31:0];
                    e.ovf = prod[32];
                    e.age = 1;
                    q.push_back(e);
                    mptr = int'(gid);
                    n_issued++;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
    endtask

    // Requesters hold until granted, then drop; bounded so a missing grant cannot hang.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] g;
        req_valid = mask;
        for (int n = 0; n < 20 && req_valid != '0; n++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            next_cycle();
            req_valid = req_valid & ~g;
        end
        check_output("grant_timeout", 32'(req_valid), 32'd0);
        req_valid = '0;
    endtask

    initial begin : stim
        logic [32:0]        p;
        logic [NUM_REQ-1:0] g;
        logic [NUM_REQ-1:0] exp_rr;
        req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;

        p = fpmul(32'h40000000, 32'h40400000);
        check_output("fpmul_2x3", p[31:0], 32'h40C00000);
        p = fpmul(32'h3FC00000, 32'h3FC00000);
        check_output("fpmul_1p5sq", p[31:0], 32'h40100000);
        p = fpmul(32'hC0000000, 32'h40800000);
        check_output("fpmul_neg", p[31:0], 32'hC1000000);
        p = fpmul(32'h7F000000, 32'h7F000000);
        check_output("fpmul_ovf", 32'(p[32]), 32'd1);

        req_valid = '1;
        repeat (3) @(negedge clk);
        check_output("reset_req_ready", 32'(req_ready), 32'd0);
        check_output("reset_mul_en", 32'(mul_en), 32'd1);
        next_cycle();
        req_valid = '0;
        reset = 1'b1;

        $display("[TB] single op");
        set_op(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        @(negedge clk);
        check_output("single_grant", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_output("single_early", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_output("single_valid", 32'(resp_valid), 32'd1);
        check_output("single_id", 32'(resp_id), 32'd0);
        check_output("single_result", resp_result, 32'h40C00000);
        check_output("single_ovf", 32'(resp_overflow), 32'd0);
        next_cycle();

        $display("[TB] round robin");
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_rr = NUM_REQ'(1 << (k % NUM_REQ));
            check_output("rr_grant", 32'(req_ready), 32'(exp_rr));
            if (k >= 2) begin
                check_output("rr_resp_id", 32'(resp_id), 32'((k - 2) % NUM_REQ));
                check_output("rr_resp_result", resp_result, 32'h40100000);
            end
            next_cycle();
        end
        req_valid = '0;
        repeat (3) next_cycle();

        $display("[TB] backpressure");
        set_op(1, 32'h40000000, 32'h3F800000);
        req_valid = 4'b0010;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        resp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_output("bp_resp_valid", 32'(resp_valid), 32'd1);
            check_output("bp_mul_en", 32'(mul_en), 32'd0);
            check_output("bp_req_ready", 32'(req_ready), 32'd0);
            check_output("bp_in_flight", 32'(in_flight), 32'd2);
            check_output("bp_resp_id", 32'(resp_id), 32'd1);
            check_output("bp_resp_result", resp_result, 32'h40000000);
            next_cycle();
        end
        resp_ready = 1'b1;
        repeat (3) next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        $display("[TB] overflow and sign");
        set_op(2, 32'h7F000000, 32'h7F000000);
        set_op(3, 32'hC0000000, 32'h40800000);
        apply_stimulus(4'b1100);
        @(negedge clk);
        check_output("ovf_id", 32'(resp_id), 32'd2);
        check_output("ovf_flag", 32'(resp_overflow), 32'd1);
        @(negedge clk);
        check_output("neg_id", 32'(resp_id), 32'd3);
        check_output("neg_result", resp_result, 32'hC1000000);
        next_cycle();

        $display("[TB] reset mid-operation");
        set_op(0, 32'h40000000, 32'h40400000);
        set_op(1, 32'h40000000, 32'h40400000);
        apply_stimulus(4'b0011);
        @(negedge clk);
        check_output("mid_in_flight", 32'(in_flight), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_resp_valid", 32'(resp_valid), 32'd0);
        check_output("mid_in_flight_clr", 32'(in_flight), 32'd0);
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
        set_op(0, 32'h40000000, 32'h40000000);
        req_valid = 4'b0001;
        @(negedge clk);
        check_output("post_grant", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_output("post_no_stale", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_output("post_valid", 32'(resp_valid), 32'd1);
        check_output("post_result", resp_result, 32'h40800000);
        next_cycle();

        $display("[TB] sparse requests");
        set_op(2, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0100;
        @(negedge clk);
        check_output("sparse_grant2", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        next_cycle();
        set_op(1, 32'h40400000, 32'h40000000);
        req_valid = 4'b0010;
        @(negedge clk);
        check_output("sparse_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        $display("[TB] random traffic");
        g = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            req_valid = req_valid & ~g;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && ($urandom_range(2) == 0)) begin
                    set_op(i, $urandom(), $urandom());
                    req_valid[i] = 1'b1;
                end
            end
            resp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            g = req_valid & req_ready;
            next_cycle();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (5) next_cycle();
        @(negedge clk);
        check_output("drain_in_flight", 32'(in_flight), 32'd0);
        check_output("no_loss", 32'(n_retired), 32'(n_issued));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
